hazard_scoreboard_unit: RTL and testbench

//  Next-generation hazard control for the RV32 pipeline. Adds a register scoreboard for

---
 rtl/hazard_scoreboard_unit_if.sv | 65 ++++++
 rtl/hazard_scoreboard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard-unit bus: pipeline-side register/control fields in, stall/flush/forward controls out.
// The package carries the PC source encoding shared by the core and this unit.
package hazard_pkg;
    typedef enum logic [1:0] {
        PC_SRC_PLUS4      = 2'b00,
        PC_SRC_ALU_RESULT = 2'b01
    } pcSrc_e;
endpackage

interface hazard_if
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 4
) ();
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_PENDING + 1);

    // ID stage
    logic [AW-1:0] rs1_id;
    logic [AW-1:0] rs2_id;
    logic          rs1_use_id;
    logic          rs2_use_id;
    logic [AW-1:0] rd_id;
    logic          reg_write_id;
    logic          long_id;
    // EX stage
    logic [AW-1:0] rs1_ex;
    logic [AW-1:0] rs2_ex;
    logic [AW-1:0] rd_ex;
    logic          lu_issue_ex;
    // MEM / WB writers
    logic [AW-1:0] rd_mem;
    logic          reg_write_mem;
    logic [AW-1:0] rd_wb;
    logic          reg_write_wb;
    logic          lu_done_wb;
    logic [AW-1:0] lu_rd_wb;
    pcSrc_e        pc_sel;
    // hazard controls
    logic          pc_en;
    logic          if_id_en;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic [1:0]    fwd_a_ex;
    logic [1:0]    fwd_b_ex;
    logic [CW-1:0] pending_cnt;
    logic          hazard_timeout;

    modport master (
        output rs1_id, rs2_id, rs1_use_id, rs2_use_id, rd_id, reg_write_id, long_id,
        output rs1_ex, rs2_ex, rd_ex, lu_issue_ex,
        output rd_mem, reg_write_mem, rd_wb, reg_write_wb, lu_done_wb, lu_rd_wb, pc_sel,
        input  pc_en, if_id_en, flush_if_id, flush_id_ex, fwd_a_ex, fwd_b_ex,
        input  pending_cnt, hazard_timeout
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_use_id, rs2_use_id, rd_id, reg_write_id, long_id,
        input  rs1_ex, rs2_ex, rd_ex, lu_issue_ex,
        input  rd_mem, reg_write_mem, rd_wb, reg_write_wb, lu_done_wb, lu_rd_wb, pc_sel,
        output pc_en, if_id_en, flush_if_id, flush_id_ex, fwd_a_ex, fwd_b_ex,
        output pending_cnt, hazard_timeout
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control beside ID/EX: a per-register scoreboard for long-latency units
// (LSU wait states, iterative MUL/DIV) drives RAW/WAW/capacity stalls, taken
// branches flush the front end, EX operands get MEM/WB forwarding selects, and
// a sticky watchdog flags stalls that never resolve.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int AW            = $clog2(NUM_REGS),
    parameter int MAX_PENDING   = 4,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int TW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0]        CNT_MAX   = CW'(MAX_PENDING);
    localparam logic signed [CW+1:0] CNT_LIMIT = (CW+2)'(MAX_PENDING);
    localparam logic [TW-1:0]        WD_MAX    = TW'(STALL_TIMEOUT);

    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  issue_hit;
    logic [NUM_REGS-1:0]  done_hit;
    logic [NUM_REGS-1:0]  busy;
    logic [CW-1:0]        pending_cnt;
    logic signed [CW+1:0] cnt_proj;
    logic                 raw;
    logic                 waw;
    logic                 full;
    logic                 stall;
    logic                 br;
    logic [TW-1:0]        wd_cnt;
    logic                 timeout;

    // MEM has the younger value, so it beats WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] mem_rd,
        input logic          mem_we,
        input logic [AW-1:0] wb_rd,
        input logic          wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Per-register busy view for this cycle: an issue sets, a completion clears,
    // and an issue to the same register as a completion wins (the new writer
    // is still outstanding). This is also exactly the next scoreboard state.
    always_comb begin
        issue_hit = '0;
        done_hit  = '0;
        busy      = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            issue_hit[i] = hz.lu_issue_ex && (hz.rd_ex == AW'(i));
            done_hit[i]  = hz.lu_done_wb && (hz.lu_rd_wb == AW'(i));
            busy[i]      = (pending[i] || issue_hit[i]) && !(done_hit[i] && !issue_hit[i]);
        end
    end

    // Stall sources and branch override; the capacity check looks at the
    // occupancy this cycle's issue/done would leave behind.
    always_comb begin
        cnt_proj = $signed({2'b00, pending_cnt})
                 + $signed({{(CW+1){1'b0}}, hz.lu_issue_ex})
                 - $signed({{(CW+1){1'b0}}, hz.lu_done_wb});
        raw   = (hz.rs1_use_id && busy[hz.rs1_id]) || (hz.rs2_use_id && busy[hz.rs2_id]);
        waw   = hz.long_id && hz.reg_write_id && busy[hz.rd_id];
        full  = hz.long_id && (cnt_proj >= CNT_LIMIT);
        stall = raw || waw || full;
        br    = (hz.pc_sel == PC_SRC_ALU_RESULT);
    end

    // Scoreboard bits; flushes never touch them, only completions do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= busy;
        end
    end

    // In-flight counter, saturating at both ends so a stray completion after
    // reset cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_cnt <= '0;
        end else begin
            case ({hz.lu_issue_ex, hz.lu_done_wb})
                2'b10: if (pending_cnt != CNT_MAX) pending_cnt <= pending_cnt + 1'b1;
                2'b01: if (pending_cnt != '0) pending_cnt <= pending_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Watchdog: counts back-to-back stall cycles not overridden by a branch;
    // the flag latches in the same edge the count reaches the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (stall && !br) begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt >= WD_MAX - 1'b1) timeout <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign hz.pc_en          = br || !stall;
    assign hz.if_id_en       = br || !stall;
    assign hz.flush_if_id    = br;
    assign hz.flush_id_ex    = br || stall;
    assign hz.fwd_a_ex       = fwd_sel(hz.rs1_ex, hz.rd_mem, hz.reg_write_mem, hz.rd_wb, hz.reg_write_wb);
    assign hz.fwd_b_ex       = fwd_sel(hz.rs2_ex, hz.rd_mem, hz.reg_write_mem, hz.rd_wb, hz.reg_write_wb);
    assign hz.pending_cnt    = pending_cnt;
    assign hz.hazard_timeout = timeout;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: each stimulus cycle pushes the
// hand-computed output vector; a monitor pops and compares on the falling edge.
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    localparam int NUM_REGS      = 32;
    localparam int MAX_PENDING   = 4;
    localparam int STALL_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if #(.NUM_REGS(NUM_REGS), .MAX_PENDING(MAX_PENDING)) hz ();

    hazard_scoreboard_unit #(
        .NUM_REGS(NUM_REGS),
        .MAX_PENDING(MAX_PENDING),
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
    );

    // expected vector: {pc_en, if_id_en, flush_if_id, flush_id_ex, fwd_a[1:0], fwd_b[1:0], cnt[2:0], timeout}
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] mon_exp;
    logic [11:0] mon_act;
    string       mon_name;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = {hz.pc_en, hz.if_id_en, hz.flush_if_id, hz.flush_id_ex,
                            hz.fwd_a_ex, hz.fwd_b_ex, hz.pending_cnt, hz.hazard_timeout};
                total++;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got pc/ifid/flif/flex/fa/fb/cnt/tmo=%b_%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b_%b",
                             mon_name, mon_act[11], mon_act[10], mon_act[9], mon_act[8], mon_act[7:6],
                             mon_act[5:4], mon_act[3:1], mon_act[0], mon_exp[11], mon_exp[10], mon_exp[9],
                             mon_exp[8], mon_exp[7:6], mon_exp[5:4], mon_exp[3:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic idle();
        hz.rs1_id = '0; hz.rs2_id = '0; hz.rs1_use_id = 1'b0; hz.rs2_use_id = 1'b0;
        hz.rd_id = '0; hz.reg_write_id = 1'b0; hz.long_id = 1'b0;
        hz.rs1_ex = '0; hz.rs2_ex = '0; hz.rd_ex = '0; hz.lu_issue_ex = 1'b0;
        hz.rd_mem = '0; hz.reg_write_mem = 1'b0; hz.rd_wb = '0; hz.reg_write_wb = 1'b0;
        hz.lu_done_wb = 1'b0; hz.lu_rd_wb = '0; hz.pc_sel = PC_SRC_PLUS4;
    endtask

    task automatic step(input string name, input logic pc, input logic fii, input logic fie,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [2:0] cnt,
                        input logic tmo);
        exp_q.push_back({pc, pc, fii, fie, fa, fb, cnt, tmo});
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        hz.lu_issue_ex = 1'b1; hz.rd_ex = r;
    endtask

    task automatic done(input logic [4:0] r);
        hz.lu_done_wb = 1'b1; hz.lu_rd_wb = r;
    endtask

    task automatic read1(input logic [4:0] r);
        hz.rs1_use_id = 1'b1; hz.rs1_id = r;
    endtask

    logic [4:0] drain_regs [5] = '{5'd2, 5'd3, 5'd4, 5'd11, 5'd12};

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        rst = 1'b0;

        // load-use on x5, completion three cycles later
        idle(); issue(5); read1(5);   step("t1_loaduse", 0, 0, 1, 2'b00, 2'b00, 3'd0, 0);
        idle(); read1(5);             step("t1_wait1",   0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        idle(); read1(5);             step("t1_wait2",   0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        idle(); read1(5); done(5);    step("t1_release", 1, 0, 0, 2'b00, 2'b00, 3'd1, 0);
        idle(); read1(5);             step("t1_after",   1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // issue and complete x7 together: new writer keeps it busy
        idle(); issue(7);             step("t2_issue", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle(); issue(7); done(7); hz.rs2_use_id = 1'b1; hz.rs2_id = 5'd7;
                                      step("t2_same",  0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        idle(); hz.rs2_use_id = 1'b1; hz.rs2_id = 5'd7;
                                      step("t2_still", 0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        idle(); done(7); hz.rs2_use_id = 1'b1; hz.rs2_id = 5'd7;
                                      step("t2_release", 1, 0, 0, 2'b00, 2'b00, 3'd1, 0);
        idle();                       step("t2_idle",    1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // completion of a non-pending register with nothing in flight
        idle(); done(9);              step("nonpend_done", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle();                       step("sat_zero",     1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // capacity: four in flight, then a long op on a free rd
        for (int i = 1; i <= 4; i++) begin
            idle(); issue(5'(i));     step("t3_fill", 1, 0, 0, 2'b00, 2'b00, 3'(i - 1), 0);
        end
        idle(); hz.long_id = 1'b1; hz.reg_write_id = 1'b1; hz.rd_id = 5'd10;
                                      step("t3_full",      0, 0, 1, 2'b00, 2'b00, 3'd4, 0);
        idle(); hz.long_id = 1'b1; hz.reg_write_id = 1'b1; hz.rd_id = 5'd10; done(1);
                                      step("t3_full_done", 1, 0, 0, 2'b00, 2'b00, 3'd4, 0);
        idle(); issue(11);            step("t3_refill",    1, 0, 0, 2'b00, 2'b00, 3'd3, 0);
        idle(); issue(12);            step("t3_sat_max",   1, 0, 0, 2'b00, 2'b00, 3'd4, 0);
        idle();                       step("t3_hold",      1, 0, 0, 2'b00, 2'b00, 3'd4, 0);
        for (int i = 0; i < 5; i++) begin
            idle(); done(drain_regs[i]);
            step("t3_drain", 1, 0, 0, 2'b00, 2'b00, (i == 4) ? 3'd0 : 3'(4 - i), 0);
        end
        idle();                       step("t3_drained",   1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // write-after-write against a pending long op
        idle(); issue(13);            step("waw_issue", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle(); hz.long_id = 1'b1; hz.reg_write_id = 1'b1; hz.rd_id = 5'd13;
                                      step("waw_stall", 0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        idle(); hz.long_id = 1'b1; hz.rd_id = 5'd13;
                                      step("waw_nowrite", 1, 0, 0, 2'b00, 2'b00, 3'd1, 0);
        idle(); done(13);             step("waw_done",  1, 0, 0, 2'b00, 2'b00, 3'd1, 0);
        idle();                       step("waw_idle",  1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // forwarding selects
        idle(); hz.rd_mem = 5'd3; hz.reg_write_mem = 1'b1; hz.rd_wb = 5'd3; hz.reg_write_wb = 1'b1;
                hz.rs1_ex = 5'd3;     step("fwd_mem_wins", 1, 0, 0, 2'b10, 2'b00, 3'd0, 0);
        idle(); hz.reg_write_mem = 1'b1; hz.reg_write_wb = 1'b1;
                                      step("fwd_x0",       1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle(); hz.rd_mem = 5'd4; hz.reg_write_mem = 1'b1; hz.rd_wb = 5'd6; hz.reg_write_wb = 1'b1;
                hz.rs1_ex = 5'd6; hz.rs2_ex = 5'd4;
                                      step("fwd_split",    1, 0, 0, 2'b01, 2'b10, 3'd0, 0);
        idle(); hz.rd_mem = 5'd6; hz.rd_wb = 5'd6; hz.reg_write_wb = 1'b1;
                hz.rs1_ex = 5'd6; hz.rs2_ex = 5'd6;
                                      step("fwd_wb_only",  1, 0, 0, 2'b01, 2'b01, 3'd0, 0);
        idle(); hz.rd_mem = 5'd6; hz.rd_wb = 5'd6; hz.rs1_ex = 5'd6; hz.rs2_ex = 5'd6;
                                      step("fwd_none",     1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // branch over stall clears the watchdog, then a long stall trips it
        idle(); issue(8); read1(8);   step("wd_s1", 0, 0, 1, 2'b00, 2'b00, 3'd0, 0);
        for (int i = 0; i < 5; i++) begin
            idle(); read1(8);         step("wd_s", 0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        end
        idle(); read1(8); hz.pc_sel = PC_SRC_ALU_RESULT;
                                      step("br_over_stall", 1, 1, 1, 2'b00, 2'b00, 3'd1, 0);
        for (int i = 0; i < 8; i++) begin
            idle(); read1(8);         step("wd_t", 0, 0, 1, 2'b00, 2'b00, 3'd1, 0);
        end
        idle(); read1(8);             step("wd_tripped", 0, 0, 1, 2'b00, 2'b00, 3'd1, 1);
        idle(); read1(8); done(8);    step("wd_release", 1, 0, 0, 2'b00, 2'b00, 3'd1, 1);
        idle();                       step("wd_sticky",  1, 0, 0, 2'b00, 2'b00, 3'd0, 1);
        idle(); hz.pc_sel = PC_SRC_ALU_RESULT;
                                      step("br_only",    1, 1, 1, 2'b00, 2'b00, 3'd0, 1);

        // asynchronous reset in the middle of a stall
        idle(); issue(9); read1(9);   step("rst_pre",   0, 0, 1, 2'b00, 2'b00, 3'd0, 1);
        rst = 1'b1;
        idle(); read1(9);             step("rst_async", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle(); read1(9); done(9);    step("rst_hold",  1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        rst = 1'b0;
        idle(); read1(9); done(9);    step("post_rst_done", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);
        idle();                       step("post_rst_idle", 1, 0, 0, 2'b00, 2'b00, 3'd0, 0);

        // every pushed expectation must have been consumed within a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
